// File: rtl/wb_pkg.sv
// Shared binary-clock panel definitions: FSM encoding and 12 MHz timing defaults.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } btn_state_e;

    localparam int unsigned WB_CLK_HZ          = 12000000;
    localparam int unsigned WB_DEBOUNCE_CYCLES = 240000;
    localparam int unsigned WB_LONG_CYCLES     = 12000000;
    localparam int unsigned WB_REPEAT_CYCLES   = 3000000;

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser plus stability counter for one active-low panel button.
module debounce
    import wb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = WB_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_n,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;

    always_comb begin
        sync_d   = {sync_q[0], din_n};
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync_q[1] != stable_q) begin
            if (db_cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Everything resets to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            db_cnt_q <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign level = stable_q;

endmodule

// File: rtl/button_ctrl.sv
// Front-panel button: debounced level plus short/long/auto-repeat event pulses.
module button_ctrl
    import wb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = WB_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = WB_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = WB_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pressed,
    output logic short_press,
    output logic long_press,
    output logic repeat_tick
);

    localparam int unsigned HW = $clog2(LONG_CYCLES);
    localparam int unsigned RW = $clog2(REPEAT_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    logic level;

    btn_state_e    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          tick_q, tick_d;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .din_n (btn_n),
        .level (level)
    );

    assign pressed = ~level;

    // Release is tested first so it wins over the long threshold.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        short_d    = 1'b0;
        long_d     = 1'b0;
        tick_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pressed) begin
                    state_d    = ST_HELD;
                    hold_cnt_d = '0;
                end
            end
            ST_HELD: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = ST_LONG;
                    long_d    = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_LONG: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                end else if (rep_cnt_q == REP_LAST) begin
                    tick_d    = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            short_q    <= short_d;
            long_q     <= long_d;
            tick_q     <= tick_d;
        end
    end

    assign short_press = short_q;
    assign long_press  = long_q;
    assign repeat_tick = tick_q;

endmodule

// File: tb/tb_button_ctrl.sv
// Randomised and directed checks of button_ctrl against a history-window model.
module tb_button_ctrl;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic btn_n = 1'b1;
    logic pressed, short_press, long_press, repeat_tick;

    button_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L),
        .REPEAT_CYCLES(R)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_n       (btn_n),
        .pressed     (pressed),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_tick (repeat_tick)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Model: raw samples per edge; stable flips after D consecutive
    // differing samples seen through the 2-cycle synchroniser.
    bit hist[$];
    bit m_stable = 1'b1;
    bit m_pressed = 1'b0;
    bit in_sess = 1'b0;
    int age = 0;
    bit e_short, e_long, e_rep;

    task automatic model_reset();
        hist.delete();
        m_stable  = 1'b1;
        m_pressed = 1'b0;
        in_sess   = 1'b0;
        age       = 0;
        e_short   = 1'b0;
        e_long    = 1'b0;
        e_rep     = 1'b0;
    endtask

    task automatic tick();
        bit seen, flip, s;
        @(posedge clk);
        cyc++;
        e_short = 1'b0;
        e_long  = 1'b0;
        e_rep   = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            hist.push_back(btn_n);
            if (hist.size() > D + 4) void'(hist.pop_front());
            seen = m_pressed;
            flip = 1'b1;
            for (int i = 2; i <= D + 1; i++) begin
                int idx;
                idx = hist.size() - 1 - i;
                s = (idx >= 0) ? hist[idx] : 1'b1;
                if (s == m_stable) flip = 1'b0;
            end
            if (flip) m_stable = ~m_stable;
            if (!in_sess) begin
                if (seen) begin
                    in_sess = 1'b1;
                    age = 0;
                end
            end else begin
                age++;
                if (!seen) begin
                    in_sess = 1'b0;
                    if (age <= L) e_short = 1'b1;
                end else if (age == L) begin
                    e_long = 1'b1;
                end else if (age > L && (age - L) % R == 0) begin
                    e_rep = 1'b1;
                end
            end
            m_pressed = ~m_stable;
        end
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({pressed, short_press, long_press, repeat_tick} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_async: got=%b exp=0000",
                     {pressed, short_press, long_press, repeat_tick});
        end
        btn_n = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            tests++;
            if ({pressed, short_press, long_press, repeat_tick} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_hold c=%0d: got=%b exp=0000", c,
                         {pressed, short_press, long_press, repeat_tick});
            end
        end
        btn_n = 1'b1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            tests++;
            if ({pressed, short_press, long_press, repeat_tick} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_idle c=%0d: got=%b exp=0000", c,
                         {pressed, short_press, long_press, repeat_tick});
            end
        end
    endtask

    task automatic test_glitch();
        int hits = 0;
        for (int c = 0; c < 40; c++) begin
            btn_n = (c < 20 && (c % 4) != 3) ? 1'b0 : 1'b1;
            tick();
            if (pressed | short_press | long_press | repeat_tick) hits++;
            tests++;
            if ({pressed, short_press, long_press, repeat_tick} !==
                {m_pressed, e_short, e_long, e_rep}) begin
                fails++;
                $display("FAIL glitch c=%0d: got=%b exp=%b", c,
                         {pressed, short_press, long_press, repeat_tick},
                         {m_pressed, e_short, e_long, e_rep});
            end
        end
        tests++;
        if (hits != 0) begin
            fails++;
            $display("FAIL glitch_any: got=%0d active cycles exp=0", hits);
        end
    endtask

    task automatic test_short();
        int k = 0, rise = -1, n_s = 0, n_o = 0;
        for (int c = 0; c < 40; c++) begin
            btn_n = (c < 12) ? 1'b0 : 1'b1;
            tick();
            if (c == 0) k = cyc;
            if (pressed && rise < 0) rise = cyc;
            n_s += short_press;
            n_o += long_press + repeat_tick;
            tests++;
            if ({pressed, short_press, long_press, repeat_tick} !==
                {m_pressed, e_short, e_long, e_rep}) begin
                fails++;
                $display("FAIL short c=%0d: got=%b exp=%b", c,
                         {pressed, short_press, long_press, repeat_tick},
                         {m_pressed, e_short, e_long, e_rep});
            end
        end
        tests++;
        if (rise != k + D + 1) begin
            fails++;
            $display("FAIL short_rise: got=%0d exp=%0d", rise - k, D + 1);
        end
        tests++;
        if (n_s != 1 || n_o != 0) begin
            fails++;
            $display("FAIL short_count: got short=%0d other=%0d exp 1/0", n_s, n_o);
        end
    endtask

    task automatic test_long();
        int k = 0, n_l = 0, n_r = 0, n_s = 0, t_l = -1, t_r1 = -1, t_r2 = -1;
        for (int c = 0; c < 90; c++) begin
            btn_n = (c < 60) ? 1'b0 : 1'b1;
            tick();
            if (c == 0) k = cyc;
            if (long_press) begin
                n_l++;
                t_l = cyc;
            end
            if (repeat_tick) begin
                n_r++;
                if (n_r == 1) t_r1 = cyc;
                if (n_r == 2) t_r2 = cyc;
            end
            n_s += short_press;
            tests++;
            if ({pressed, short_press, long_press, repeat_tick} !==
                {m_pressed, e_short, e_long, e_rep}) begin
                fails++;
                $display("FAIL long c=%0d: got=%b exp=%b", c,
                         {pressed, short_press, long_press, repeat_tick},
                         {m_pressed, e_short, e_long, e_rep});
            end
        end
        tests++;
        if (n_l != 1 || t_l != k + D + 1 + L + 1) begin
            fails++;
            $display("FAIL long_edge: got n=%0d at %0d exp 1 at %0d",
                     n_l, t_l - k, D + L + 2);
        end
        tests++;
        if (t_r1 != t_l + R || t_r2 != t_l + 2 * R || n_r != 4) begin
            fails++;
            $display("FAIL long_repeat: got n=%0d r1=%0d r2=%0d exp 4 %0d %0d",
                     n_r, t_r1 - t_l, t_r2 - t_l, R, 2 * R);
        end
        tests++;
        if (n_s != 0) begin
            fails++;
            $display("FAIL long_noshort: got=%0d exp=0", n_s);
        end
    endtask

    task automatic test_collision();
        int k = 0, n_s = 0, n_l = 0, t_s = -1;
        for (int c = 0; c < 50; c++) begin
            btn_n = (c < L) ? 1'b0 : 1'b1;
            tick();
            if (c == 0) k = cyc;
            if (short_press) begin
                n_s++;
                t_s = cyc;
            end
            n_l += long_press;
            tests++;
            if ({pressed, short_press, long_press, repeat_tick} !==
                {m_pressed, e_short, e_long, e_rep}) begin
                fails++;
                $display("FAIL collide c=%0d: got=%b exp=%b", c,
                         {pressed, short_press, long_press, repeat_tick},
                         {m_pressed, e_short, e_long, e_rep});
            end
        end
        tests++;
        if (n_s != 1 || n_l != 0 || t_s != k + D + 1 + L + 1) begin
            fails++;
            $display("FAIL collide_pulse: got s=%0d l=%0d at %0d exp 1/0 at %0d",
                     n_s, n_l, t_s - k, D + L + 2);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0, rise = -1, t_l = -1;
        for (int c = 0; c < 40; c++) begin
            btn_n = 1'b0;
            tick();
            tests++;
            if ({pressed, short_press, long_press, repeat_tick} !==
                {m_pressed, e_short, e_long, e_rep}) begin
                fails++;
                $display("FAIL mid_pre c=%0d: got=%b exp=%b", c,
                         {pressed, short_press, long_press, repeat_tick},
                         {m_pressed, e_short, e_long, e_rep});
            end
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        tests++;
        if ({pressed, short_press, long_press, repeat_tick} !== 4'b0000) begin
            fails++;
            $display("FAIL mid_async: got=%b exp=0000",
                     {pressed, short_press, long_press, repeat_tick});
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 0) k = cyc;
            if (pressed && rise < 0) rise = cyc;
            if (long_press && t_l < 0) t_l = cyc;
            tests++;
            if ({pressed, short_press, long_press, repeat_tick} !==
                {m_pressed, e_short, e_long, e_rep}) begin
                fails++;
                $display("FAIL mid_post c=%0d: got=%b exp=%b", c,
                         {pressed, short_press, long_press, repeat_tick},
                         {m_pressed, e_short, e_long, e_rep});
            end
        end
        tests++;
        if (rise - k + 1 != D + 2 || t_l != rise + L + 1) begin
            fails++;
            $display("FAIL mid_restart: got rise=%0d long=%0d exp %0d %0d",
                     rise - k + 1, t_l - rise, D + 2, L + 1);
        end
        btn_n = 1'b1;
        for (int c = 0; c < 20; c++) tick();
    endtask

    task automatic test_random();
        int seg = 0;
        for (int c = 0; c < 2000; c++) begin
            if (seg == 0) begin
                btn_n = ($urandom_range(0, 1) == 1);
                seg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                  : $urandom_range(1, 45);
            end
            seg--;
            tick();
            tests++;
            if ({pressed, short_press, long_press, repeat_tick} !==
                {m_pressed, e_short, e_long, e_rep} ||
                $countones({short_press, long_press, repeat_tick}) > 1) begin
                fails++;
                $display("FAIL random c=%0d: got=%b exp=%b", c,
                         {pressed, short_press, long_press, repeat_tick},
                         {m_pressed, e_short, e_long, e_rep});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_glitch();
        test_short();
        test_long();
        test_collision();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
